// File: rtl/user_pkg.sv
// Shared user-domain definitions: copy-manager sizing, OBI byte-enable constant
// and the word-alignment helper used when latching byte addresses.
package user_pkg;

    localparam int UserCopyLenWidth = 16;
    localparam logic [3:0] UserObiBeAll = 4'hF;

    function automatic logic [31:0] wordAlign(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/user_obi_copy_mgr.sv
// User-domain OBI copy manager: moves a block of 32-bit words from a source to a
// destination address, one OBI transaction outstanding at a time.
module user_obi_copy_mgr
    import user_pkg::*;
#(
    parameter int LenWidth = UserCopyLenWidth,
    parameter int IdWidth  = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [31:0]         cfg_src_i,
    input  logic [31:0]         cfg_dst_i,
    input  logic [LenWidth-1:0] cfg_len_i,
    input  logic                cfg_src_inc_i,
    input  logic                cfg_dst_inc_i,
    input  logic                start_i,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [LenWidth-1:0] words_done_o,
    output logic                obi_req_o,
    input  logic                obi_gnt_i,
    output logic [31:0]         obi_addr_o,
    output logic                obi_we_o,
    output logic [3:0]          obi_be_o,
    output logic [31:0]         obi_wdata_o,
    output logic [IdWidth-1:0]  obi_aid_o,
    input  logic                obi_rvalid_i,
    input  logic [31:0]         obi_rdata_i,
    input  logic                obi_err_i,
    input  logic [IdWidth-1:0]  obi_rid_i
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        FINISH
    } state_e;

    localparam logic [LenWidth-1:0] LenOne = LenWidth'(1);

    state_e              state_q, state_d;
    logic [31:0]         src_q, src_d;
    logic [31:0]         dst_q, dst_d;
    logic [LenWidth-1:0] len_q, len_d;
    logic [LenWidth-1:0] cnt_q, cnt_d;
    logic                srcInc_q, srcInc_d;
    logic                dstInc_q, dstInc_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [31:0]         nextSrc, nextDst;

    // Response IDs carry no information with a single outstanding transaction.
    logic unused;
    assign unused = ^obi_rid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            srcInc_q <= 1'b0;
            dstInc_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            srcInc_q <= srcInc_d;
            dstInc_q <= dstInc_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Address and write data are loaded on entry to a request state, so they are
    // already stable in the first cycle req is high and cannot move until gnt.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        srcInc_d = srcInc_q;
        dstInc_d = dstInc_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        nextSrc  = srcInc_q ? src_q + 32'd4 : src_q;
        nextDst  = dstInc_q ? dst_q + 32'd4 : dst_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    src_d    = wordAlign(cfg_src_i);
                    dst_d    = wordAlign(cfg_dst_i);
                    len_d    = cfg_len_i;
                    srcInc_d = cfg_src_inc_i;
                    dstInc_d = cfg_dst_inc_i;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                    if (cfg_len_i == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = RD_REQ;
                        addr_d  = wordAlign(cfg_src_i);
                        we_d    = 1'b0;
                    end
                end
            end
            RD_REQ: begin
                if (obi_gnt_i) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (obi_rvalid_i) begin
                    if (obi_err_i) begin
                        err_d   = 1'b1;
                        state_d = FINISH;
                    end else begin
                        wdata_d = obi_rdata_i;
                        addr_d  = dst_q;
                        we_d    = 1'b1;
                        state_d = WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (obi_gnt_i) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                // Abort is only honoured here, after the word's write has landed.
                if (obi_rvalid_i) begin
                    if (obi_err_i) begin
                        err_d   = 1'b1;
                        state_d = FINISH;
                    end else begin
                        cnt_d = cnt_q + LenOne;
                        src_d = nextSrc;
                        dst_d = nextDst;
                        if ((cnt_d == len_q) || abort_i) begin
                            state_d = FINISH;
                        end else begin
                            state_d = RD_REQ;
                            addr_d  = nextSrc;
                            we_d    = 1'b0;
                        end
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign obi_req_o    = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign obi_addr_o   = addr_q;
    assign obi_we_o     = we_q;
    assign obi_be_o     = UserObiBeAll;
    assign obi_wdata_o  = wdata_q;
    assign obi_aid_o    = '0;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign words_done_o = cnt_q;

endmodule

// File: tb/tb_user_obi_copy_mgr.sv
// Self-checking bench for user_obi_copy_mgr: an OBI subordinate model with
// programmable grant/response delays and a transaction-list reference model.
module tb_user_obi_copy_mgr;
    import user_pkg::*;

    localparam int LenW = UserCopyLenWidth;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [31:0]     cfg_src_i = '0;
    logic [31:0]     cfg_dst_i = '0;
    logic [LenW-1:0] cfg_len_i = '0;
    logic            cfg_src_inc_i = 1'b0;
    logic            cfg_dst_inc_i = 1'b0;
    logic            start_i = 1'b0;
    logic            abort_i = 1'b0;
    logic            busy_o, done_o, err_o;
    logic [LenW-1:0] words_done_o;
    logic            obi_req_o, obi_gnt_i, obi_we_o, obi_rvalid_i, obi_err_i;
    logic [31:0]     obi_addr_o, obi_wdata_o, obi_rdata_i;
    logic [3:0]      obi_be_o;
    logic [0:0]      obi_aid_o, obi_rid_i;

    user_obi_copy_mgr #(.LenWidth(LenW), .IdWidth(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_src_i(cfg_src_i), .cfg_dst_i(cfg_dst_i), .cfg_len_i(cfg_len_i),
        .cfg_src_inc_i(cfg_src_inc_i), .cfg_dst_inc_i(cfg_dst_inc_i),
        .start_i(start_i), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .words_done_o(words_done_o),
        .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
        .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
        .obi_aid_o(obi_aid_o), .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i),
        .obi_err_i(obi_err_i), .obi_rid_i(obi_rid_i)
    );

    initial forever #5 clk_i = ~clk_i;

    int testCount = 0;
    int failCount = 0;
    int cycle = 0;
    int startCycle = 0;

    logic [31:0] logAddr[$];
    bit          logWe[$];
    logic [31:0] logData[$];
    int          rdDelay[16];
    int          wrDelay[16];
    int          respExtra = 0;
    int          nRd = 0, nWr = 0;
    bit          pending = 0;
    int          respCnt = 0;
    logic [31:0] respData = '0;
    bit          respErr = 0;
    int          waitCnt = 0;
    bit          reqHeld = 0;
    logic [31:0] heldAddr, heldData;
    bit          heldWe;
    int          protoErr = 0;
    int          doneCount = 0;
    int          doneCycle = 0;
    int          reqCycles = 0;
    bit          busyAtDone = 0;

    initial forever @(posedge clk_i) cycle++;

    function automatic bit inErrWindow(input logic [31:0] a);
        return a[31:12] == 20'h20005;
    endfunction

    // Subordinate driver: decides gnt/rvalid for each new cycle.
    initial begin
        obi_gnt_i = 0; obi_rvalid_i = 0; obi_rdata_i = '0; obi_err_i = 0; obi_rid_i = '0;
        forever begin
            @(posedge clk_i); #1;
            if (rst_i) begin
                obi_gnt_i = 0; obi_rvalid_i = 0; waitCnt = 0;
            end else begin
                if (pending && respCnt == 0) begin
                    obi_rvalid_i = 1; obi_rdata_i = respData; obi_err_i = respErr;
                end else begin
                    obi_rvalid_i = 0; obi_rdata_i = $urandom; obi_err_i = 1'($urandom_range(0, 1));
                    if (pending) respCnt--;
                end
                if (obi_req_o) begin
                    obi_gnt_i = (waitCnt >= (obi_we_o ? wrDelay[nWr % 16] : rdDelay[nRd % 16]));
                    waitCnt++;
                end else begin
                    obi_gnt_i = 0; waitCnt = 0;
                end
            end
        end
    end

    // Subordinate monitor: logs granted transactions and flags protocol breaches.
    initial begin
        bit wasPending;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                pending = 0; reqHeld = 0;
            end else begin
                wasPending = pending;
                if (obi_rvalid_i) pending = 0;
                if (obi_req_o) begin
                    reqCycles++;
                    if (wasPending) protoErr++;
                    if (obi_be_o !== 4'hF) protoErr++;
                    if (reqHeld && (obi_addr_o !== heldAddr || obi_we_o !== heldWe ||
                                    obi_wdata_o !== heldData)) protoErr++;
                    if (obi_gnt_i) begin
                        logAddr.push_back(obi_addr_o);
                        logWe.push_back(obi_we_o);
                        respData = $urandom;
                        if (obi_we_o) begin
                            logData.push_back(obi_wdata_o); nWr++;
                        end else begin
                            logData.push_back(respData); nRd++;
                        end
                        respErr = inErrWindow(obi_addr_o);
                        pending = 1; respCnt = respExtra; reqHeld = 0;
                    end else begin
                        reqHeld = 1; heldAddr = obi_addr_o; heldWe = obi_we_o; heldData = obi_wdata_o;
                    end
                end else begin
                    if (reqHeld) protoErr++;
                    reqHeld = 0;
                end
            end
            if (done_o) begin
                doneCount++; doneCycle = cycle; busyAtDone = busy_o;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req"}, 64'(obi_req_o), 0);
        checkOutput({tag, "_we"}, 64'(obi_we_o), 0);
        checkOutput({tag, "_addr"}, 64'(obi_addr_o), 0);
        checkOutput({tag, "_wdata"}, 64'(obi_wdata_o), 0);
        checkOutput({tag, "_be"}, 64'(obi_be_o), 64'hF);
        checkOutput({tag, "_aid"}, 64'(obi_aid_o), 0);
        checkOutput({tag, "_busy"}, 64'(busy_o), 0);
        checkOutput({tag, "_done"}, 64'(done_o), 0);
        checkOutput({tag, "_err"}, 64'(err_o), 0);
        checkOutput({tag, "_words"}, 64'(words_done_o), 0);
    endtask

    task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input int len,
                                 input bit si, input bit di);
        logAddr.delete(); logWe.delete(); logData.delete();
        nRd = 0; nWr = 0; doneCount = 0; reqCycles = 0; protoErr = 0;
        @(posedge clk_i); #1;
        cfg_src_i = src; cfg_dst_i = dst; cfg_len_i = LenW'(len);
        cfg_src_inc_i = si; cfg_dst_inc_i = di;
        start_i = 1; startCycle = cycle;
        @(posedge clk_i); #1;
        start_i = 0;
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        while (doneCount == 0 && n < 400) begin
            @(posedge clk_i); n++;
        end
        checkOutput({tag, "_doneSeen"}, 64'(doneCount != 0), 1);
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    // Reference model: rebuilds the expected R/W sequence from the job parameters
    // and the data the subordinate handed out, then compares with the log.
    task automatic checkJob(input string tag, input logic [31:0] src, input logic [31:0] dst,
                            input int len, input bit si, input bit di,
                            input int abortWord, input int expDone);
        int expN = 0, mism = 0, words = 0;
        bit e = 0;
        logic [31:0] a, d;
        d = '0;
        for (int i = 0; i < len; i++) begin
            a = {src[31:2], 2'b00} + (si ? 32'(4 * i) : 32'd0);
            if (expN < logAddr.size()) begin
                if (logAddr[expN] !== a || logWe[expN] !== 1'b0) mism++;
                d = logData[expN];
            end else mism++;
            expN++;
            if (inErrWindow(a)) begin e = 1; break; end
            a = {dst[31:2], 2'b00} + (di ? 32'(4 * i) : 32'd0);
            if (expN < logAddr.size()) begin
                if (logAddr[expN] !== a || logWe[expN] !== 1'b1 || logData[expN] !== d) mism++;
            end else mism++;
            expN++;
            if (inErrWindow(a)) begin e = 1; break; end
            words++;
            if (i == abortWord) break;
        end
        checkOutput({tag, "_txnCount"}, 64'(logAddr.size()), 64'(expN));
        checkOutput({tag, "_txnList"}, 64'(mism), 0);
        checkOutput({tag, "_words"}, 64'(words_done_o), 64'(words));
        checkOutput({tag, "_err"}, 64'(err_o), 64'(e));
        checkOutput({tag, "_donePulses"}, 64'(doneCount), 1);
        checkOutput({tag, "_busyAtDone"}, 64'(busyAtDone), 0);
        checkOutput({tag, "_protocol"}, 64'(protoErr), 0);
        if (expDone >= 0)
            checkOutput({tag, "_doneCycle"}, 64'(doneCycle - startCycle), 64'(expDone));
    endtask

    task automatic zeroDelays();
        for (int k = 0; k < 16; k++) begin rdDelay[k] = 0; wrDelay[k] = 0; end
        respExtra = 0;
    endtask

    initial begin
        int snap, n;
        logic [31:0] rs, rd;
        int rl;
        bit rsi, rdi;
        zeroDelays();

        repeat (3) @(negedge clk_i);
        checkResetValues("reset");
        @(posedge clk_i); #1 rst_i = 0;

        // PRNG to SPI, fixed addresses, zero-wait subordinate.
        applyStimulus(32'h2000_2000, 32'h2000_0000, 3, 0, 0);
        checkOutput("prng_busyC1", 64'(busy_o), 1);
        checkOutput("prng_reqC1", 64'(obi_req_o), 1);
        waitDone("prng");
        checkJob("prng", 32'h2000_2000, 32'h2000_0000, 3, 0, 0, -1, 14);

        // Unaligned incrementing source.
        applyStimulus(32'h2000_3003, 32'h2000_0000, 2, 1, 0);
        waitDone("font");
        checkJob("font", 32'h2000_3003, 32'h2000_0000, 2, 1, 0, -1, 10);
        checkOutput("font_rd1Addr", 64'(logAddr.size() > 2 ? logAddr[2] : 32'h0), 64'h2000_3004);

        // Grant withheld for five cycles on the second read.
        rdDelay[1] = 5;
        applyStimulus(32'h2000_2000, 32'h2000_0000, 3, 0, 0);
        waitDone("gntDelay");
        checkJob("gntDelay", 32'h2000_2000, 32'h2000_0000, 3, 0, 0, -1, 19);
        zeroDelays();

        // Destination in the error subordinate.
        applyStimulus(32'h2000_2000, 32'h2000_5000, 3, 0, 0);
        waitDone("errDst");
        repeat (6) @(posedge clk_i);
        checkJob("errDst", 32'h2000_2000, 32'h2000_5000, 3, 0, 0, -1, 6);

        // Abort raised while word 1's read is outstanding; a start while busy is ignored.
        applyStimulus(32'h2000_2000, 32'h2000_1000, 8, 0, 1);
        n = 0;
        while (logAddr.size() < 3 && n < 100) begin @(posedge clk_i); n++; end
        #1 abort_i = 1;
        @(posedge clk_i); #1;
        cfg_src_i = 32'h2000_3000; cfg_len_i = LenW'(1); start_i = 1;
        @(posedge clk_i); #1 start_i = 0;
        waitDone("abort");
        abort_i = 0;
        repeat (8) @(posedge clk_i);
        checkJob("abort", 32'h2000_2000, 32'h2000_1000, 8, 0, 1, 1, -1);

        // Zero-length job.
        applyStimulus(32'h2000_2000, 32'h2000_0000, 0, 0, 0);
        checkOutput("len0_busyC1", 64'(busy_o), 1);
        waitDone("len0");
        checkJob("len0", 32'h2000_2000, 32'h2000_0000, 0, 0, 0, -1, 2);
        checkOutput("len0_noReq", 64'(reqCycles), 0);

        // Destination wraps from the top of the address space to zero.
        applyStimulus(32'h2000_2000, 32'hFFFF_FFFC, 2, 0, 1);
        waitDone("wrap");
        checkJob("wrap", 32'h2000_2000, 32'hFFFF_FFFC, 2, 0, 1, -1, 10);

        // Randomized jobs with random grant and response latencies.
        for (int j = 0; j < 5; j++) begin
            rs  = 32'h2000_3000 + 32'($urandom_range(0, 1023)) * 4 + 32'($urandom_range(0, 3));
            rd  = 32'h2000_0000 + 32'($urandom_range(0, 1023)) * 4;
            rl  = $urandom_range(1, 6);
            rsi = 1'($urandom_range(0, 1));
            rdi = 1'($urandom_range(0, 1));
            for (int k = 0; k < 16; k++) begin
                rdDelay[k] = $urandom_range(0, 2); wrDelay[k] = $urandom_range(0, 2);
            end
            respExtra = $urandom_range(0, 2);
            applyStimulus(rs, rd, rl, rsi, rdi);
            waitDone("rand");
            checkJob("rand", rs, rd, rl, rsi, rdi, -1, -1);
        end
        zeroDelays();

        // Synchronous reset while a write request is waiting for grant.
        wrDelay[0] = 4;
        applyStimulus(32'h2000_2000, 32'h2000_0000, 2, 0, 0);
        n = 0;
        while (!(obi_req_o && obi_we_o) && n < 50) begin @(posedge clk_i); #1; n++; end
        checkOutput("rstWr_reached", 64'(obi_req_o && obi_we_o), 1);
        rst_i = 1;
        @(posedge clk_i); #1 rst_i = 0;
        checkResetValues("rstWr");
        snap = reqCycles;
        repeat (6) @(posedge clk_i);
        checkOutput("rstWr_quiet", 64'(reqCycles - snap), 0);
        checkOutput("rstWr_noDone", 64'(doneCount), 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
